// File: rtl/sr_stack_fifo_pkg.sv
// rtl/sr_stack_fifo_pkg.sv - shared defaults and request encoding for the push/pop FIFO
package sr_stack_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 8;

  // Request seen in one cycle, packed as {pop, push}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sr_fifo_mem.sv
// rtl/sr_fifo_mem.sv - unreset register array, one sync write port, two async read ports
module sr_fifo_mem
  import sr_stack_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic [ADDR_WIDTH-1:0] headAddr,
  output logic [DATA_WIDTH-1:0] headData,
  input  logic [ADDR_WIDTH-1:0] peekAddr,
  output logic [DATA_WIDTH-1:0] peekData
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the pushed word; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
  end

  assign headData = mem[headAddr];
  assign peekData = mem[peekAddr];

endmodule

// File: rtl/sr_stack_fifo.sv
// rtl/sr_stack_fifo.sv - FIFO responder for the core's push/pop instructions
module sr_stack_fifo
  import sr_stack_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic [ADDR_WIDTH-1:0] peek_idx,
  output logic [DATA_WIDTH-1:0] peek_data
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [ADDR_WIDTH:0]   wrPtr;
  logic [ADDR_WIDTH:0]   rdPtr;
  logic                  pushOk;
  logic                  popOk;
  logic                  pushRej;
  logic                  popRej;
  fifo_op_e              reqOp;
  logic [DATA_WIDTH-1:0] headRaw;
  logic [DATA_WIDTH-1:0] peekRaw;
  logic [ADDR_WIDTH-1:0] peekAddr;
  logic [ADDR_WIDTH:0]   peekIdxExt;

  assign count = wrPtr - rdPtr;
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[ADDR_WIDTH] != rdPtr[ADDR_WIDTH]) &&
                 (wrPtr[ADDR_WIDTH-1:0] == rdPtr[ADDR_WIDTH-1:0]);

  assign reqOp = fifo_op_e'({pop, push});

  // Decide acceptance; a pop frees a slot so push-while-full works when paired with a pop
  always_comb begin
    pushOk = 1'b0;
    popOk  = 1'b0;
    if (!clr) begin
      case (reqOp)
        OP_PUSH: pushOk = !full;
        OP_POP:  popOk  = !empty;
        OP_BOTH: begin
          popOk  = !empty;
          pushOk = !full || !empty;
        end
        default: begin
          pushOk = 1'b0;
          popOk  = 1'b0;
        end
      endcase
    end
  end

  // clr swallows any same-cycle request, so it never raises a sticky flag
  assign pushRej = push && !clr && !pushOk;
  assign popRej  = pop  && !clr && !popOk;

  // Pointer and sticky-flag state; clr flushes by catching rdPtr up to wrPtr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      rdPtr     <= wrPtr;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (popOk) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      if (pushRej) begin
        overflow <= 1'b1;
      end
      if (popRej) begin
        underflow <= 1'b1;
      end
    end
  end

  assign peekAddr   = rdPtr[ADDR_WIDTH-1:0] + peek_idx;
  assign peekIdxExt = {1'b0, peek_idx};

  sr_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) uMem (
    .clk      (clk),
    .we       (pushOk),
    .wAddr    (wrPtr[ADDR_WIDTH-1:0]),
    .wData    (push_data),
    .headAddr (rdPtr[ADDR_WIDTH-1:0]),
    .headData (headRaw),
    .peekAddr (peekAddr),
    .peekData (peekRaw)
  );

  // Stale storage must never leak out, so both read views are gated by occupancy
  assign pop_data  = empty ? '0 : headRaw;
  assign peek_data = (peekIdxExt < count) ? peekRaw : '0;

endmodule

// File: tb/tb_sr_stack_fifo.sv
// tb/tb_sr_stack_fifo.sv - scoreboard bench for sr_stack_fifo
module tb_sr_stack_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop = 1'b0;
  logic [DW-1:0] pop_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic [AW-1:0] peek_idx = '0;
  logic [DW-1:0] peek_data;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] modelQ[$];
  logic [DW-1:0] expQ[$];
  bit            expOvf = 0;
  bit            expUnf = 0;
  logic [DW-1:0] monExp;

  sr_stack_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .peek_idx  (peek_idx),
    .peek_data (peek_data)
  );

  always #5 clk = ~clk;

  // Scoreboard: every pop cycle is matched against the expectation queued at drive time
  always @(negedge clk) begin
    if (pop && !rst && !clr) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL pop_scoreboard got=%h required=<no expectation queued>", pop_data);
      end else begin
        monExp = expQ.pop_front();
        if (pop_data !== monExp) begin
          failures++;
          $display("FAIL pop_data got=%h required=%h", pop_data, monExp);
        end
      end
    end
  end

  task automatic drive(input bit p, input logic [DW-1:0] d, input bit q);
    bit popAcc;
    bit pushAcc;
    push = p;
    push_data = d;
    pop = q;
    if (q) expQ.push_back(modelQ.size() > 0 ? modelQ[0] : '0);
    popAcc  = q && (modelQ.size() > 0);
    pushAcc = p && ((modelQ.size() < DEPTH) || popAcc);
    if (popAcc) void'(modelQ.pop_front());
    if (pushAcc) modelQ.push_back(d);
    if (p && !pushAcc) expOvf = 1;
    if (q && !popAcc) expUnf = 1;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
  endtask

  task automatic do_clr(input bit p);
    clr = 1'b1;
    push = p;
    push_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    clr = 1'b0;
    push = 1'b0;
    modelQ.delete();
    expOvf = 0;
    expUnf = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset_occupancy got count=%0d empty=%b full=%b required 0 1 0", count, empty, full);
    end
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || pop_data !== '0 || peek_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ovf=%b unf=%b pop=%h peek=%h required all 0", overflow, underflow, pop_data, peek_data);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    drive(1, 32'h11, 0);
    drive(1, 32'h22, 0);
    drive(1, 32'h33, 0);
    checks++;
    if (count !== 4'd3) begin
      failures++;
      $display("FAIL basic_count3 got=%0d required=3", count);
    end
    for (int i = 0; i < 3; i++) drive(0, '0, 1);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL basic_drained got count=%0d empty=%b ovf=%b unf=%b required 0 1 0 0", count, empty, overflow, underflow);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) drive(1, i, 0);
    checks++;
    if (full !== 1'b1 || count !== 4'd8) begin
      failures++;
      $display("FAIL ovf_full got full=%b count=%0d required 1 8", full, count);
    end
    drive(1, 32'h99, 0);
    checks++;
    if (overflow !== expOvf || overflow !== 1'b1 || count !== 4'd8) begin
      failures++;
      $display("FAIL ovf_flag got ovf=%b count=%0d required 1 8", overflow, count);
    end
    for (int i = 0; i < DEPTH; i++) drive(0, '0, 1);
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b1 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drained got empty=%b ovf=%b unf=%b required 1 1 0", empty, overflow, underflow);
    end
    do_clr(0);
    checks++;
    if (overflow !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL ovf_clr got ovf=%b empty=%b required 0 1", overflow, empty);
    end
  endtask

  task automatic test_full_both();
    for (int i = 0; i < DEPTH; i++) drive(1, i, 0);
    drive(1, 32'hAA, 1);
    checks++;
    if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_both got count=%0d full=%b ovf=%b required 8 1 0", count, full, overflow);
    end
    for (int i = 0; i < DEPTH; i++) drive(0, '0, 1);
    checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      failures++;
      $display("FAIL full_both_drain got empty=%b count=%0d required 1 0", empty, count);
    end
  endtask

  task automatic test_empty_both();
    drive(1, 32'h55, 1);
    checks++;
    if (underflow !== 1'b1 || count !== 4'd1 || underflow !== expUnf) begin
      failures++;
      $display("FAIL empty_both got unf=%b count=%0d required 1 1", underflow, count);
    end
    drive(0, '0, 1);
    checks++;
    if (empty !== 1'b1 || underflow !== 1'b1) begin
      failures++;
      $display("FAIL empty_both_after got empty=%b unf=%b required 1 1", empty, underflow);
    end
    do_clr(0);
  endtask

  task automatic test_peek();
    logic [DW-1:0] want;
    drive(1, 32'hA, 0);
    drive(1, 32'hB, 0);
    drive(1, 32'hC, 0);
    for (int k = 0; k < 4; k++) begin
      peek_idx = AW'(k);
      #1;
      want = (k < modelQ.size()) ? modelQ[k] : '0;
      checks++;
      if (peek_data !== want) begin
        failures++;
        $display("FAIL peek idx=%0d got=%h required=%h", k, peek_data, want);
      end
    end
    peek_idx = '0;
    for (int i = 0; i < 3; i++) drive(0, '0, 1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'h100 + i, 0);
      if (i % 3 != 0) drive(0, '0, 1);
      if (i % 4 == 3) drive(1, 32'h200 + i, 1);
    end
    while (modelQ.size() > 0) drive(0, '0, 1);
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL wrap_end got empty=%b ovf=%b unf=%b required 1 0 0", empty, overflow, underflow);
    end
  endtask

  task automatic test_clr();
    drive(0, '0, 1);
    drive(1, 32'h1, 0);
    drive(1, 32'h2, 0);
    drive(1, 32'h3, 0);
    checks++;
    if (underflow !== 1'b1 || count !== 4'd3) begin
      failures++;
      $display("FAIL clr_setup got unf=%b count=%0d required 1 3", underflow, count);
    end
    do_clr(1);
    checks++;
    if (empty !== 1'b1 || count !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0 || pop_data !== '0) begin
      failures++;
      $display("FAIL clr_push got empty=%b count=%0d ovf=%b unf=%b pop=%h required 1 0 0 0 0", empty, count, overflow, underflow, pop_data);
    end
  endtask

  task automatic test_async_rst();
    drive(1, 32'h71, 0);
    drive(1, 32'h72, 0);
    drive(0, '0, 1);
    push = 1'b1;
    push_data = 32'h73;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || pop_data !== '0 || peek_data !== '0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got count=%0d empty=%b full=%b pop=%h peek=%h ovf=%b required 0 1 0 0 0 0", count, empty, full, pop_data, peek_data, overflow);
    end
    @(posedge clk);
    #1;
    push = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelQ.delete();
    expOvf = 0;
    expUnf = 0;
    @(posedge clk);
    #1;
    drive(0, '0, 1);
    checks++;
    if (empty !== 1'b1 || underflow !== 1'b1) begin
      failures++;
      $display("FAIL post_rst got empty=%b unf=%b required 1 1", empty, underflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_both();
    test_empty_both();
    test_peek();
    test_wrap();
    test_clr();
    test_async_rst();
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
